// File: rtl/pad_filter_pkg.sv
// Shared types and constants for the pad input filter and its synchroniser.
// Edge-select encoding matches the 2-bit edge_sel_i field of the interface.
package pad_filter_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_sel_e;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } filt_state_e;

endpackage

// File: rtl/pad_input_filter_if.sv
// Control/status bundle between a pad-input consumer (master) and the filter (slave).
// The master drives the pad value and configuration; the slave returns the filtered results.
interface pad_input_filter_if #(
    parameter int CNT_W = 8
);
    logic             pad_val_i;
    logic             en_i;
    logic [CNT_W-1:0] debounce_cycles_i;
    logic [1:0]       edge_sel_i;
    logic             irq_clr_i;
    logic             filt_o;
    logic             rise_o;
    logic             fall_o;
    logic             irq_o;

    modport master (
        output pad_val_i, en_i, debounce_cycles_i, edge_sel_i, irq_clr_i,
        input  filt_o, rise_o, fall_o, irq_o
    );

    modport slave (
        input  pad_val_i, en_i, debounce_cycles_i, edge_sel_i, irq_clr_i,
        output filt_o, rise_o, fall_o, irq_o
    );
endinterface

// File: rtl/pad_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit pad signal.
// Stage count is clamped to the minimum that still provides metastability settling.
module pad_sync
    import pad_filter_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    localparam int NUM_STAGES = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [NUM_STAGES-1:0] sync_reg;
    logic [NUM_STAGES-1:0] sync_next;

    assign sync_next[0] = d_i;

    for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_stage
        assign sync_next[gi] = sync_reg[gi-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg <= {NUM_STAGES{RESET_VAL}};
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign q_o = sync_reg[NUM_STAGES-1];
endmodule

// File: rtl/pad_input_filter.sv
// Pad-to-core input conditioning: synchronise, debounce, then flag filtered edges
// as one-cycle pulses and a sticky, clearable interrupt.
module pad_input_filter
    import pad_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pad_input_filter_if.slave  bus
);
    logic             s;
    filt_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             filt_reg, filt_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             irq_reg, irq_next;
    logic             irq_set;

    pad_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bus.pad_val_i),
        .q_o   (s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
            filt_reg  <= RESET_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            filt_reg  <= filt_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            irq_reg   <= irq_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        filt_next  = filt_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        if (!bus.en_i) begin
            // Track the level silently so re-enabling never reports a stale edge.
            state_next = STABLE;
            cnt_next   = '0;
            filt_next  = s;
        end else begin
            case (state_reg)
                STABLE: begin
                    if (s != filt_reg) begin
                        if (bus.debounce_cycles_i == '0) begin
                            filt_next = s;
                            rise_next = s;
                            fall_next = ~s;
                        end else begin
                            state_next = CHECK;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (s == filt_reg) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg >= bus.debounce_cycles_i) begin
                        // Compare before incrementing so the counter can never wrap.
                        filt_next  = s;
                        rise_next  = s;
                        fall_next  = ~s;
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        irq_set = 1'b0;
        case (edge_sel_e'(bus.edge_sel_i))
            EDGE_RISE: irq_set = rise_reg;
            EDGE_FALL: irq_set = fall_reg;
            EDGE_BOTH: irq_set = rise_reg | fall_reg;
            default:   irq_set = 1'b0;
        endcase

        irq_next = irq_reg;
        if (bus.irq_clr_i) begin
            irq_next = 1'b0;
        end
        if (irq_set) begin
            irq_next = 1'b1;
        end
    end

    assign bus.filt_o = filt_reg;
    assign bus.rise_o = rise_reg;
    assign bus.fall_o = fall_reg;
    assign bus.irq_o  = irq_reg;
endmodule

// File: tb/tb_pad_input_filter.sv
// Directed bench for pad_input_filter: hand-computed timing of filtered level,
// edge pulses and interrupt across debounce, bypass, disable and reset cases.
module tb_pad_input_filter;
    import pad_filter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic pad_model;

    always #5 clk = ~clk;

    pad_input_filter_if #(.CNT_W(8)) bus ();

    pad_input_filter #(
        .SYNC_STAGES (2),
        .CNT_W       (8),
        .RESET_VAL   (1'b0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic f, input logic r,
                           input logic fa, input logic i);
        chk({tag, ".filt"}, bus.filt_o, f);
        chk({tag, ".rise"}, bus.rise_o, r);
        chk({tag, ".fall"}, bus.fall_o, fa);
        chk({tag, ".irq"},  bus.irq_o,  i);
    endtask

    initial begin
        bus.pad_val_i         = 1'b0;
        bus.en_i              = 1'b0;
        bus.debounce_cycles_i = 8'd0;
        bus.edge_sel_i        = EDGE_NONE;
        bus.irq_clr_i         = 1'b0;

        // Reset state
        step(2);
        rst = 1'b0;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn reset: filt=%0b irq=%0b", bus.filt_o, bus.irq_o);

        // 1: debounced rise, N=3 -> 6-cycle latency
        bus.en_i = 1'b1;
        bus.debounce_cycles_i = 8'd3;
        bus.edge_sel_i = EDGE_RISE;
        bus.pad_val_i = 1'b1;
        step(5);
        chk_out("t1_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_out("t1_commit", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("t1_irq", 1'b1, 1'b0, 1'b0, 1'b1);
        $display("txn t1 rise N=3: filt=%0b irq=%0b", bus.filt_o, bus.irq_o);

        // 2: return low (fall does not match RISE), clear irq, then glitches
        bus.pad_val_i = 1'b0;
        step(6);
        chk_out("t2_fall", 1'b0, 1'b0, 1'b1, 1'b1);
        bus.irq_clr_i = 1'b1;
        step(1);
        bus.irq_clr_i = 1'b0;
        chk("t2_clr.irq", bus.irq_o, 1'b0);
        bus.pad_val_i = 1'b1;
        step(1);
        bus.pad_val_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_out("t2_glitch1", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.pad_val_i = 1'b1;
        step(3);
        bus.pad_val_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk_out("t2_glitch3", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        $display("txn t2 glitches: filt=%0b irq=%0b", bus.filt_o, bus.irq_o);

        // 3: bypass N=0, BOTH edges, toggle every 4 cycles
        bus.debounce_cycles_i = 8'd0;
        bus.edge_sel_i = EDGE_BOTH;
        pad_model = 1'b0;
        for (int t = 0; t < 4; t++) begin
            pad_model = ~pad_model;
            bus.pad_val_i = pad_model;
            step(2);
            chk("t3_lat.filt", bus.filt_o, ~pad_model);
            step(1);
            chk_out("t3_edge", pad_model, pad_model, ~pad_model, (t != 0));
            step(1);
            chk_out("t3_after", pad_model, 1'b0, 1'b0, 1'b1);
            $display("txn t3 toggle %0d: pad=%0b filt=%0b", t, pad_model, bus.filt_o);
        end

        // 4: clear coincident with a matching fall pulse -> set wins
        bus.pad_val_i = 1'b1;
        step(4);
        chk("t4_high.filt", bus.filt_o, 1'b1);
        bus.edge_sel_i = EDGE_FALL;
        bus.pad_val_i = 1'b0;
        step(3);
        chk_out("t4_fall", 1'b0, 1'b0, 1'b1, 1'b1);
        bus.irq_clr_i = 1'b1;
        step(1);
        chk("t4_setwins.irq", bus.irq_o, 1'b1);
        step(1);
        bus.irq_clr_i = 1'b0;
        chk("t4_clr.irq", bus.irq_o, 1'b0);
        $display("txn t4 set-vs-clear: irq=%0b", bus.irq_o);

        // 5: disabled follow, quiet re-enable, then N=255 saturation
        bus.en_i = 1'b0;
        bus.debounce_cycles_i = 8'd3;
        bus.edge_sel_i = EDGE_BOTH;
        bus.pad_val_i = 1'b1;
        step(2);
        chk_out("t5_dis_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_out("t5_dis_follow", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk_out("t5_reen", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        bus.debounce_cycles_i = 8'd255;
        bus.edge_sel_i = EDGE_FALL;
        bus.pad_val_i = 1'b0;
        step(257);
        chk_out("t5_sat_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_out("t5_sat_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1);
        chk("t5_sat_irq.irq", bus.irq_o, 1'b1);
        $display("txn t5 N=255: filt=%0b irq=%0b", bus.filt_o, bus.irq_o);

        // 6: reset mid-CHECK, then lower N mid-CHECK
        bus.debounce_cycles_i = 8'd10;
        bus.edge_sel_i = EDGE_RISE;
        bus.pad_val_i = 1'b1;
        step(4);
        chk_out("t6_midcheck", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_out("t6_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        step(7);
        chk_out("t6_cnt5", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.debounce_cycles_i = 8'd1;
        step(1);
        chk_out("t6_lowerN", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("t6_irq", 1'b1, 1'b0, 1'b0, 1'b1);
        $display("txn t6 reset/lowerN: filt=%0b irq=%0b", bus.filt_o, bus.irq_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pad_input_filter.md
Name: pad_input_filter

Overview:
- Sits directly downstream of the bidirectional pad cell and consumes its pad output value (the pad-to-core input).
- Synchronises the asynchronous pad value into the core clock domain, rejects glitches with a programmable debounce counter, and produces the filtered level.
- Also produces single-cycle rise/fall pulses and a sticky, clearable edge interrupt for the GPIO/interrupt controller.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (minimum 2).
- CNT_W, 8, width of the debounce counter and of debounce_cycles_i.
- RESET_VAL, 1'b0, reset value of the synchroniser flops and of the filtered level.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  reset; synchronous, active-high.
- pad_val_i  input  1  asynchronous value from the pad cell output.
- en_i  input  1  filter/edge-detect enable.
- debounce_cycles_i  input  CNT_W  N, the debounce length; 0 = bypass.
- edge_sel_i  input  2  interrupt edge select: 0 none, 1 rising, 2 falling, 3 both.
- irq_clr_i  input  1  clears irq_o.
- filt_o  output  1  filtered, synchronised level.
- rise_o  output  1  one-cycle pulse on a filtered 0->1 transition.
- fall_o  output  1  one-cycle pulse on a filtered 1->0 transition.
- irq_o  output  1  sticky edge interrupt.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - synchroniser flops = RESET_VAL, filt_o = RESET_VAL.
  - counter = 0, state = STABLE.
  - rise_o = 0, fall_o = 0, irq_o = 0.
  - Reset asserted mid-CHECK aborts the debounce with no pulse.
- Synchroniser: s is the output of the SYNC_STAGES-flop chain, with no reset bypass.
- FSM states STABLE and CHECK; cnt is CNT_W bits; N = debounce_cycles_i, sampled every cycle.
- STABLE:
  - if s != filt_o and N == 0: filt_o <= s.
  - if s != filt_o and N != 0: go to CHECK, cnt <= 1.
  - otherwise hold.
- CHECK:
  - s == filt_o: glitch rejected; go to STABLE, cnt <= 0, no pulse.
  - else cnt >= N: filt_o <= s; go to STABLE, cnt <= 0.
  - else cnt <= cnt + 1. cnt saturates and never wraps, because cnt >= N is checked first.
- A filtered change therefore requires s to differ for N+1 consecutive cycles.
- Latency: a pad step held stable produces a filt_o change SYNC_STAGES + N + 1 cycles later.
- N lowered mid-CHECK: the >= comparison commits on the next cycle. N raised: counting continues toward the new N.
- Pulses: rise_o/fall_o are registered and asserted for exactly one cycle, in the same cycle filt_o first shows the new value. They are never asserted together.
- irq_o:
  - set when a pulse matches edge_sel_i (both = either pulse).
  - cleared by irq_clr_i.
  - simultaneous set and clear: set wins.
  - edge_sel_i = 0 never sets irq_o; an already-set irq_o is held.
  - edge_sel_i changes take effect in the same cycle.
- en_i low:
  - state forced to STABLE, cnt = 0.
  - filt_o <= s every cycle.
  - rise_o/fall_o = 0; irq_o holds and clr still works.
  - Re-enabling therefore never emits a spurious edge for a level already present.
- Register all outputs; no combinational path from inputs to outputs.

Decomposition:
- Package pad_filter_pkg:
  - edge_sel_e enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
  - filt_state_e enum (STABLE, CHECK).
  - localparam MIN_SYNC_STAGES = 2.
- One sub-module: pad_sync, a parameterised N-flop synchroniser with clk_i, rst_i and reset value. It is instantiated once and is reusable by other pad-input consumers.

Test Plan:
1. Reset, en_i=1, N=3, edge_sel=RISE; pad 0->1 held → filt_o rises exactly 2+3+1=6 cycles later, rise_o high for 1 cycle in that cycle, irq_o=1 from the next cycle.
2. N=3; pad 1-cycle and 3-cycle high glitches (s differs 3 < 4 cycles) → filt_o stays 0, no pulses, irq_o stays 0; FSM returns to STABLE.
3. N=0, edge_sel=BOTH; pad toggles every 4 cycles → filt_o follows with 3-cycle latency, alternating rise_o/fall_o pulses, irq_o set after the first edge.
4. irq_o=1, irq_clr_i asserted in the same cycle as a new fall_o with edge_sel=FALL → irq_o stays 1; clr alone on the next cycle → irq_o=0.
5. en_i=0 with pad 0->1 → filt_o follows after 3 cycles, rise_o never asserts; en_i back to 1 → no pulse. Then N=255: a held change commits after 2+255+1 cycles, confirming counter saturation with no wrap.
6. Mid-CHECK (cnt=2, N=10) assert rst_i for 1 cycle → all outputs return to reset values next cycle; lower N from 10 to 1 mid-CHECK with cnt=5 → filt_o commits on the following cycle.
